// File: rtl/ui_sub_arbiter_if.sv
// rtl/ui_sub_arbiter_if.sv - request/result bundle for the shared subtractor arbiter
interface ui_sub_arbiter_if #(
  parameter int N   = 64,
  parameter int R   = 4,
  parameter int IDW = 2
);
  logic [R-1:0]   req_valid;
  logic [R*N-1:0] req_a;
  logic [R*N-1:0] req_b;
  logic [R-1:0]   req_ready;
  logic           res_valid;
  logic [N-1:0]   res_c;
  logic           res_borrow;
  logic [IDW-1:0] res_id;
  logic           res_ready;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_c, res_borrow, res_id
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_c, res_borrow, res_id
  );
endinterface

// File: rtl/ui_sub_arbiter.sv
// rtl/ui_sub_arbiter.sv - round-robin shared N-bit subtractor, two-stage pipeline
module ui_sub_arbiter #(
  parameter int N   = 64,
  parameter int R   = 4,
  parameter int IDW = 2
) (
  input  logic              clk,
  input  logic              rst,
  ui_sub_arbiter_if.slave   bus,
  output logic              busy
);
  logic           s1_valid, s2_valid;
  logic [N-1:0]   s1_a, s1_b;
  logic [IDW-1:0] s1_id;
  logic [N-1:0]   s2_c;
  logic           s2_borrow;
  logic [IDW-1:0] s2_id;
  logic [IDW-1:0] ptr;

  logic           s2_load, s1_accept;
  logic           grant_any, take;
  logic [IDW-1:0] grant_id;
  logic [R-1:0]   grant;
  int             idx;
  int             sel;

  assign s2_load   = s1_valid & (~s2_valid | bus.res_ready);
  assign s1_accept = ~s1_valid | s2_load;

  // Search starts at ptr and wraps at R, so non-power-of-two R never probes a phantom slot.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int k = 0; k < R; k++) begin
      idx = int'(ptr) + k;
      if (idx >= R) idx = idx - R;
      if (!grant_any && bus.req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = IDW'(idx);
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < R; i++) begin
      grant[i] = !rst && s1_accept && grant_any && (grant_id == IDW'(i));
    end
  end

  assign take = |grant;
  assign sel  = int'(grant_id) * N;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
      ptr      <= '0;
    end else if (take) begin
      s1_valid <= 1'b1;
      s1_a     <= bus.req_a[sel +: N];
      s1_b     <= bus.req_b[sel +: N];
      s1_id    <= grant_id;
      ptr      <= (grant_id == IDW'(R - 1)) ? '0 : grant_id + IDW'(1);
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_c      <= '0;
      s2_borrow <= 1'b0;
      s2_id     <= '0;
    end else if (s2_load) begin
      s2_valid  <= 1'b1;
      s2_c      <= s1_a - s1_b;
      s2_borrow <= (s1_a < s1_b);
      s2_id     <= s1_id;
    end else if (bus.res_ready && s2_valid) begin
      s2_valid  <= 1'b0;
    end
  end

  assign bus.req_ready  = grant;
  assign bus.res_valid  = s2_valid;
  assign bus.res_c      = s2_c;
  assign bus.res_borrow = s2_borrow;
  assign bus.res_id     = s2_id;
  assign busy           = s1_valid | s2_valid;
endmodule

// File: doc/ui_sub_arbiter.md
Name: ui_sub_arbiter

Overview:
Shares one N-bit unsigned subtractor datapath between R requesters. Round-robin arbitration, valid/ready handshake per requester, two-stage registered pipeline (operand register, result register) with full backpressure from a single shared result port. Result carries the requester id and a borrow flag. Sits between kernel lanes that each need occasional subtraction and the single instantiated subtract resource.

Parameters:
N, 64, operand/result word width in bits.
R, 4, number of requesters (>=2; need not be a power of 2).
IDW, 2, requester id width; must satisfy 2^IDW >= R.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  R  bit i: requester i presents operands.
req_a  in  R*N  minuend of requester i at bits [i*N +: N].
req_b  in  R*N  subtrahend of requester i at bits [i*N +: N].
req_ready  out  R  one-hot/zero grant; bit i high means requester i's operands are taken this cycle.
res_valid  out  1  result register holds a valid result.
res_c  out  N  (a - b) mod 2^N.
res_borrow  out  1  1 when a < b (unsigned).
res_id  out  IDW  index of requester that issued this result.
res_ready  in  1  consumer accepts result this cycle.
busy  out  1  any pipeline stage holds a valid entry.

Behaviour:
- Reset (async assert, released synchronously by caller): s1_valid=0, s2_valid=0, rr pointer=0, all data regs=0. Outputs: req_ready=0, res_valid=0, res_c=0, res_borrow=0, res_id=0, busy=0. Reset mid-operation discards all in-flight entries; no result emitted for them.
- Transfer on a port occurs at a rising edge where valid&ready are both high.
- s2_load = s1_valid & (!s2_valid | res_ready). s1_accept = !s1_valid | s2_load.
- Arbitration (combinational): if s1_accept, grant the first i with req_valid[i]=1 searching ptr, ptr+1, ..., R-1, 0, ..., ptr-1. req_ready = one-hot of grant, all-zero if none valid or !s1_accept. req_ready may depend combinationally on req_valid and res_ready.
- On grant of i: s1 <= {req_a[i], req_b[i], id=i}, s1_valid<=1; ptr <= (i+1) mod R (wrap from R-1 to 0; non-power-of-2 R must wrap at R, not 2^IDW). No grant: ptr unchanged; s1_valid <= 0 if s2_load else hold.
- On s2_load: res_c <= s1_a - s1_b (N bits, modulo), res_borrow <= (s1_a < s1_b), res_id <= s1_id, s2_valid<=1. If res_ready & s2_valid & !s2_load: s2_valid<=0.
- Latency: operands accepted at edge k -> res_valid high after edge k+1 (2 edges) when not stalled. Throughput one result per cycle with res_ready held high.
- Backpressure: while res_valid & !res_ready, res_c/res_borrow/res_id hold stable; s1 fills once then req_ready goes all-zero. Max 2 entries in flight.
- Simultaneous res_ready and new grant with both stages full: s2 takes s1, s1 takes new request same edge (no bubble).
- Fairness: a continuously valid requester is granted within R accepts.
- Requesters must hold req_valid and operands stable until granted; retraction is permitted but then no ordering guarantee for that requester.
- Results emerge in grant order; busy = s1_valid | s2_valid.
- Zero-width corner: a=b -> res_c=0, borrow=0; a=0,b=1 -> res_c=all-ones, borrow=1.

Test Plan:
1. Reset then single request: req_valid=0001, a=100, b=58, res_ready=1 -> req_ready=0001 one cycle, two edges later res_valid=1, res_c=42, res_borrow=0, res_id=0; busy falls next cycle.
2. Wrap/borrow: requester 2, a=0, b=1 -> res_c=2^64-1, res_borrow=1, res_id=2; a=b=5 -> res_c=0, borrow=0.
3. Round-robin: all four req_valid held high, res_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles; res_id sequence matches, one result per cycle.
4. Backpressure: all valid, res_ready=0 for 5 cycles -> exactly 2 grants (ids 0,1), req_ready=0 thereafter, res_c/res_id frozen at id 0; res_ready=1 -> ids 0,1,2,... drain with no loss or duplication.
5. R=3 build: requesters 2 and 0 valid, ptr=2 -> grant 2 then 0 (ptr wraps 2->0, never to 3).
6. Async reset asserted mid-stream with both stages full -> res_valid, busy, req_ready drop immediately (no clock edge); after release, first new request gets id-correct result, ptr restarts at 0.
